uart_rx_fifo_ctrl: RTL
======================

Name: uart_rx_fifo_ctrl

Overview:
UART receiver, the inbound counterpart of the existing UART transmit driver. It deserialises 8N1 frames from the board Rx pin and buffers bytes in a small FIFO. Bytes are exposed to the MCU over the memory-mapped IOBUS as a data port and a status port, and the block raises a one-cycle interrupt pulse per received byte. It runs on the same CLK as the UART transmit driver.

Parameters:
CLK_FREQ, 100_000_000, CLK frequency in Hz
BAUD, 115200, line rate in bit/s
FIFO_DEPTH, 8, receive FIFO entries; power of 2, minimum 2

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  synchronous, active-high reset
Rx  in  1  asynchronous serial input, idle high
rd  in  1  pop request; one byte popped per cycle while high and not empty
clr_err  in  1  clears sticky error flags
dout  out  8  FIFO head byte (first-word fall-through); 0 when empty
valid  out  1  FIFO not empty
full  out  1  FIFO full
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte received while FIFO full and not popping
intr  out  1  one-cycle pulse on each successful FIFO push

Behaviour:
- Reset (RST=1 at a CLK edge), from any state including mid-frame:
  - FSM returns to IDLE; FIFO is emptied; tick divider is cleared.
  - Synchroniser flops are set to 1.
  - Outputs: dout=0, valid=0, full=0, frame_err=0, overrun=0, intr=0.
- Rx passes through a 2-flop synchroniser before any use.
- Oversample tick:
  - DIV = CLK_FREQ/(BAUD*16), integer-rounded, minimum 1.
  - A counter produces a one-cycle tick every DIV clocks.
  - The counter restarts on entry to START so that sampling is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: synchronised Rx=0 -> START, tick count cleared.
  - START: after 8 ticks (mid start bit), sample Rx. If 0 -> DATA with bit index 0. If 1 -> IDLE (glitch rejected, no flag set).
  - DATA: every 16 ticks sample one bit into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after 16 ticks sample Rx.
    - 1: push the byte and return to IDLE.
    - 0: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronised Rx=1, then go to IDLE.
- Push rules:
  - A push occurs in the cycle the stop bit samples high.
  - intr pulses 1 in the cycle after the push (aligned with valid rising when the FIFO was empty).
  - If the FIFO is full and rd=0 that cycle: the byte is dropped, overrun is set, and intr does not pulse.
  - Simultaneous push and pop on a full FIFO: both occur, count unchanged, no overrun.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push proceeds.
- Pop: rd=1 with valid=1 advances the read pointer. dout and valid reflect the new head in the next cycle. rd while empty has no effect.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, with an extra wrap bit.
  - full = MSBs differ and LSBs are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH with no special case.
- Sticky flags:
  - frame_err and overrun clear only on clr_err or RST.
  - If clr_err and a new error coincide in the same cycle, the set wins.
- Latency: from Rx falling edge to valid=1 is 2 sync clocks + (8 + 16*8 + 16) ticks + 1 clock.

IOBUS hookup:
- UART_RX_DATA_AD: read returns {24'b0, dout}. The wrapper drives rd for one cycle on the read.
- UART_RX_STAT_AD: read returns {28'b0, overrun, frame_err, full, valid}. A write to this address pulses clr_err.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - OVERSAMPLE=16 and MID_SAMPLE=8
  - the UART_RX_DATA_AD and UART_RX_STAT_AD localparams, shared with the wrapper.
- One sub-module: sync_fifo (parameter WIDTH=8, DEPTH). It owns pointers, storage, full/empty and FWFT dout.
- The FSM, synchroniser and divider stay in the top module.

Test Plan:
Common bench setup: CLK_FREQ=1_600_000, BAUD=100_000, so DIV=1 and one bit lasts 16 CLKs.
1. Send frame 0xA5, rd=0 -> at 2+152+1 CLKs after the start edge, valid=1 and dout=8'hA5; intr is high for exactly 1 cycle; no error flags.
2. Pulse Rx low for 4 CLKs only, then high -> state returns to IDLE; valid stays 0; frame_err=0 and overrun=0.
3. Send 0x3C with the stop bit driven low, then Rx high -> frame_err=1 and valid=0. Then send 0x11 -> valid=1 and dout=8'h11 while frame_err remains 1. Pulse clr_err -> frame_err=0.
4. Send bytes 0x00..0x08 (9 frames) with rd=0 and FIFO_DEPTH=8 -> full=1 after the 8th byte; overrun=1 after the 9th; no intr for the 9th. Then pop 8 times -> dout sequence is 0x00..0x07, valid=0 after the last pop.
5. With the FIFO full, assert rd in the exact cycle the 9th byte's stop bit is sampled -> overrun stays 0; the pops return 0x01..0x08.
6. Assert RST during DATA bit 4 of frame 0xFF, with 2 bytes queued -> all outputs are 0 the next cycle. Then send 0x5A -> dout=8'h5A with valid=1, and no remnant of 0xFF appears.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Contents: rx_state_t receiver FSM states, oversampling constants,
// IOBUS addresses of the data/status ports, divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  localparam logic [31:0] UART_RX_DATA_AD = 32'h1100_0020;
  localparam logic [31:0] UART_RX_STAT_AD = 32'h1100_0024;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO
// Ports: clk, rst (sync active-high); wr/wdata push request; rd pop request;
// rdata head entry (0 when empty); empty, full status; wr_ok = push accepted.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             wr_ok
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd;
  logic             do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = rd && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_wr = wr && (!full || do_rd);
  assign wr_ok = do_wr;
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - 8N1 UART receiver with receive FIFO and sticky errors
// Ports: CLK, RST (sync active-high); Rx serial input (idle high);
// rd pops the FIFO head; clr_err clears sticky flags; dout FWFT head byte;
// valid/full FIFO status; frame_err, overrun sticky errors; intr push pulse.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       valid,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  output logic       intr
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  rx_state_t     state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          start_edge;
  logic          push;
  logic          push_ok;
  logic          empty;

  assign rx_s       = sync[1];
  assign tick       = (div_cnt == DW'(DIV - 1));
  assign start_edge = (state == IDLE) && !rx_s;
  // Push strobe: last tick of the stop bit with the line high.
  assign push       = (state == STOP) && tick &&
                      (tick_cnt == 4'(OVERSAMPLE - 1)) && rx_s;
  assign valid      = !empty;

  always_ff @(posedge CLK) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], Rx};
  end

  // Restarting on the start edge phase-aligns all samples to that edge.
  always_ff @(posedge CLK) begin
    if (RST || start_edge || tick) div_cnt <= '0;
    else                           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      intr      <= 1'b0;
    end else begin
      intr <= push_ok;
      // Clear first so a coincident new error below takes precedence.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (push && !push_ok) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'(MID_SAMPLE - 1)) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[7:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .wr   (push),
    .wdata(shreg),
    .rd   (rd),
    .rdata(dout),
    .empty(empty),
    .full (full),
    .wr_ok(push_ok)
  );

endmodule
